// File: rtl/i2c_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// i2c_bus_arbiter_pkg
// Shared definitions for the I2C bus arbiter:
//   - state_e    : 2-bit arbiter state encoding
//   - clog2      : ceiling log2, usable in parameter/localparam expressions
//   - idx_width  : width of a requester index (never less than 1 bit)
// -----------------------------------------------------------------------------
package i2c_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    S_WAIT_FREE = 2'd0,
    S_IDLE      = 2'd1,
    S_GRANT     = 2'd2
  } state_e;

  // Ceiling log2; clog2(1) = 0, clog2(17) = 5, clog2(1025) = 11.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Bits needed to hold an index 0..n-1, with a 1-bit floor.
  function automatic int idx_width(input int n);
    return (n > 2) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2c_bus_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches the request vector cyclically,
// starting at the requester just after last_i, and returns the first one set.
// Ports:
//   req_i          [N_REQ-1:0]  request vector
//   last_i         [IDX_W-1:0]  index of the most recent grantee
//   pick_onehot_o  [N_REQ-1:0]  one-hot winner (zero when valid_o = 0)
//   pick_idx_o     [IDX_W-1:0]  index of the winner
//   valid_o                     at least one request is pending
// -----------------------------------------------------------------------------
module rr_pick
  import i2c_bus_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N_REQ-1:0] pick_onehot_o,
  output logic [IDX_W-1:0] pick_idx_o,
  output logic             valid_o
);

  // One extra bit so last_i + N_REQ cannot overflow before the wrap.
  localparam int SW = IDX_W + 1;

  logic [IDX_W-1:0] cand_idx [N_REQ];
  logic [N_REQ-1:0] cand_hit;

  // Candidate gi is the requester (gi+1) places after the last grantee,
  // so candidate 0 has the highest priority.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
    logic [SW-1:0] sum;
    assign sum          = {1'b0, last_i} + SW'(gi + 1);
    assign cand_idx[gi] = (sum >= SW'(N_REQ)) ? IDX_W'(sum - SW'(N_REQ)) : IDX_W'(sum);
    assign cand_hit[gi] = req_i[cand_idx[gi]];
  end

  always_comb begin
    pick_idx_o = '0;
    valid_o    = 1'b0;
    // Walk from lowest priority to highest so the closest candidate wins.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (cand_hit[i]) begin
        pick_idx_o = cand_idx[i];
        valid_o    = 1'b1;
      end
    end
    pick_onehot_o = valid_o ? (N_REQ'(1) << pick_idx_o) : '0;
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// -----------------------------------------------------------------------------
// i2c_bus_arbiter
// Shares one I2C master port between N_REQ local requesters. A grant is only
// issued after the bus has been idle for BUS_FREE_CYCLES consecutive clocks;
// grants rotate round-robin, and a grantee that fails to start a transfer
// within START_TIMEOUT clocks loses the bus.
// Ports:
//   clk_i                   system clock
//   reset_n_i               asynchronous active-low reset
//   req_i      [N_REQ-1:0]  level requests, held for the whole bus use
//   transfer_in_progress_i  high between START and STOP (synchronous)
//   grant_o    [N_REQ-1:0]  registered one-hot (or zero) grant
//   bus_busy_o              registered, high whenever the state is not S_IDLE
//   timeout_o               one-cycle pulse when a grant is revoked by timeout
// -----------------------------------------------------------------------------
module i2c_bus_arbiter
  import i2c_bus_arbiter_pkg::*;
#(
  parameter int N_REQ           = 2,
  parameter int BUS_FREE_CYCLES = 16,
  parameter int START_TIMEOUT   = 1024
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic             transfer_in_progress_i,
  output logic [N_REQ-1:0] grant_o,
  output logic             bus_busy_o,
  output logic             timeout_o
);

  localparam int FREE_W = clog2(BUS_FREE_CYCLES + 1);
  localparam int TO_W   = clog2(START_TIMEOUT + 1);
  localparam int IDX_W  = idx_width(N_REQ);

  localparam logic [FREE_W-1:0] FREE_LAST = FREE_W'(BUS_FREE_CYCLES - 1);
  localparam logic [FREE_W-1:0] FREE_MAX  = FREE_W'(BUS_FREE_CYCLES);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(START_TIMEOUT - 1);
  localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(START_TIMEOUT);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_REQ - 1);

  state_e            state_q, state_d;
  logic [FREE_W-1:0] free_cnt_q, free_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              seen_start_q, seen_start_d;
  logic [IDX_W-1:0]  last_grant_q, last_grant_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic              timeout_q, timeout_d;
  logic              bus_busy_q, bus_busy_d;

  logic [FREE_W-1:0] free_inc;
  logic [TO_W-1:0]   to_inc;

  logic [N_REQ-1:0]  pick_onehot;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i         (req_i),
    .last_i        (last_grant_q),
    .pick_onehot_o (pick_onehot),
    .pick_idx_o    (pick_idx),
    .valid_o       (pick_valid)
  );

  // Saturating increments: counters hold at their ceiling instead of wrapping.
  assign free_inc = (free_cnt_q == FREE_MAX) ? free_cnt_q : free_cnt_q + 1'b1;
  assign to_inc   = (to_cnt_q == TO_MAX)     ? to_cnt_q   : to_cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    free_cnt_d   = free_cnt_q;
    to_cnt_d     = to_cnt_q;
    seen_start_d = seen_start_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    timeout_d    = 1'b0;

    case (state_q)
      S_WAIT_FREE: begin
        grant_d = '0;
        if (transfer_in_progress_i) begin
          free_cnt_d = '0;
        end else begin
          free_cnt_d = free_inc;
          if (free_cnt_q == FREE_LAST) begin
            state_d = S_IDLE;
          end
        end
      end

      S_IDLE: begin
        grant_d = '0;
        // A foreign master starting a transfer beats any local request.
        if (transfer_in_progress_i) begin
          free_cnt_d = '0;
          state_d    = S_WAIT_FREE;
        end else if (pick_valid) begin
          grant_d      = pick_onehot;
          last_grant_d = pick_idx;
          to_cnt_d     = '0;
          seen_start_d = 1'b0;
          state_d      = S_GRANT;
        end
      end

      S_GRANT: begin
        if (transfer_in_progress_i) begin
          seen_start_d = 1'b1;
        end
        if (!seen_start_q) begin
          to_cnt_d = to_inc;
        end
        // last_grant_q is the current grantee while in S_GRANT. A release
        // takes precedence over a coincident timeout, so no pulse then.
        if (!req_i[last_grant_q]) begin
          grant_d    = '0;
          free_cnt_d = '0;
          state_d    = S_WAIT_FREE;
        end else if (!seen_start_q && (to_cnt_q == TO_LAST)) begin
          grant_d    = '0;
          timeout_d  = 1'b1;
          free_cnt_d = '0;
          state_d    = S_WAIT_FREE;
        end
      end

      default: begin
        grant_d    = '0;
        free_cnt_d = '0;
        state_d    = S_WAIT_FREE;
      end
    endcase

    // Registered from the next state so bus_busy_o lines up with state_q.
    bus_busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= S_WAIT_FREE;
      free_cnt_q   <= '0;
      to_cnt_q     <= '0;
      seen_start_q <= 1'b0;
      last_grant_q <= LAST_IDX;
      grant_q      <= '0;
      timeout_q    <= 1'b0;
      bus_busy_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      free_cnt_q   <= free_cnt_d;
      to_cnt_q     <= to_cnt_d;
      seen_start_q <= seen_start_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      timeout_q    <= timeout_d;
      bus_busy_q   <= bus_busy_d;
    end
  end

  assign grant_o    = grant_q;
  assign timeout_o  = timeout_q;
  assign bus_busy_o = bus_busy_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_i2c_bus_arbiter
// Directed scenarios for i2c_bus_arbiter (N_REQ=2, BUS_FREE_CYCLES=16,
// START_TIMEOUT=1024). The stimulus process pushes expected output changes
// (grant/timeout, with the clock count at which they must appear) and
// expected snapshots into queues; the monitor process compares on the
// falling edge whenever an output changes or a snapshot is due.
// -----------------------------------------------------------------------------
module tb_i2c_bus_arbiter;

  typedef struct {
    int         cyc;
    logic [1:0] grant;
    logic       tmo;
  } ev_t;

  typedef struct {
    int         cyc;
    logic [1:0] grant;
    logic       tmo;
    logic       busy;
  } probe_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] req;
  logic       tip;
  logic [1:0] grant;
  logic       busy;
  logic       tmo;

  int     cyc = 0;
  int     n_vec = 0;
  int     n_bad = 0;
  bit     done = 1'b0;
  ev_t    ev_q[$];
  probe_t pr_q[$];

  i2c_bus_arbiter #(
    .N_REQ           (2),
    .BUS_FREE_CYCLES (16),
    .START_TIMEOUT   (1024)
  ) dut (
    .clk_i                  (clk),
    .reset_n_i              (reset_n),
    .req_i                  (req),
    .transfer_in_progress_i (tip),
    .grant_o                (grant),
    .bus_busy_o             (busy),
    .timeout_o              (tmo)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic void exp_ev(input int c, input logic [1:0] g, input logic t);
    ev_q.push_back('{cyc: c, grant: g, tmo: t});
  endfunction

  function automatic void exp_pr(input int c, input logic [1:0] g, input logic t, input logic b);
    pr_q.push_back('{cyc: c, grant: g, tmo: t, busy: b});
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard
  initial begin
    logic [1:0] prev_grant;
    logic       prev_tmo;
    ev_t        cur_ev;
    probe_t     cur_pr;
    prev_grant = 2'b00;
    prev_tmo   = 1'b0;
    forever begin
      @(negedge clk);
      if (grant !== prev_grant || tmo !== prev_tmo) begin
        n_vec = n_vec + 1;
        if (ev_q.size() == 0) begin
          n_bad = n_bad + 1;
          $display("FAIL unexpected_change: cyc=%0d grant=%b timeout=%b, no change expected",
                   cyc, grant, tmo);
        end else begin
          cur_ev = ev_q.pop_front();
          if (grant !== cur_ev.grant || tmo !== cur_ev.tmo || cyc != cur_ev.cyc) begin
            n_bad = n_bad + 1;
            $display("FAIL output_change: got cyc=%0d grant=%b timeout=%b, want cyc=%0d grant=%b timeout=%b",
                     cyc, grant, tmo, cur_ev.cyc, cur_ev.grant, cur_ev.tmo);
          end else begin
            $display("ok   output_change: cyc=%0d grant=%b timeout=%b", cyc, grant, tmo);
          end
        end
        prev_grant = grant;
        prev_tmo   = tmo;
      end
      while (pr_q.size() != 0 && pr_q[0].cyc <= cyc) begin
        cur_pr = pr_q.pop_front();
        n_vec  = n_vec + 1;
        if (cur_pr.cyc != cyc || grant !== cur_pr.grant || tmo !== cur_pr.tmo ||
            busy !== cur_pr.busy) begin
          n_bad = n_bad + 1;
          $display("FAIL snapshot: cyc=%0d grant=%b timeout=%b busy=%b, want cyc=%0d grant=%b timeout=%b busy=%b",
                   cyc, grant, tmo, busy, cur_pr.cyc, cur_pr.grant, cur_pr.tmo, cur_pr.busy);
        end else begin
          $display("ok   snapshot: cyc=%0d grant=%b timeout=%b busy=%b", cyc, grant, tmo, busy);
        end
      end
      if (done) begin
        while (ev_q.size() != 0) begin
          cur_ev = ev_q.pop_front();
          n_vec  = n_vec + 1;
          n_bad  = n_bad + 1;
          $display("FAIL missing_change: want cyc=%0d grant=%b timeout=%b, never observed",
                   cur_ev.cyc, cur_ev.grant, cur_ev.tmo);
        end
        while (pr_q.size() != 0) begin
          cur_pr = pr_q.pop_front();
          n_vec  = n_vec + 1;
          n_bad  = n_bad + 1;
          $display("FAIL missing_snapshot: want cyc=%0d, never sampled", cur_pr.cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
      end
    end
  end

  // Stimulus
  initial begin
    int         e;
    int         d;
    int         s;
    int         t;
    int         g;
    int         r;
    int         gt;
    logic [1:0] oh;

    reset_n = 1'b0;
    req     = 2'b00;
    tip     = 1'b0;
    tick(2);

    // Reset state
    exp_pr(cyc, 2'b00, 1'b0, 1'b1);
    tick(1);

    // 1) Release reset with requester 0 asking: 16 free cycles, then grant.
    req     = 2'b01;
    reset_n = 1'b1;
    e       = cyc;
    for (int k = 0; k < 16; k++) exp_pr(e + k, 2'b00, 1'b0, 1'b1);
    exp_ev(e + 17, 2'b01, 1'b0);
    exp_pr(e + 17, 2'b01, 1'b0, 1'b1);
    tick(17);

    // 2) Both requesting: grants alternate; each release is followed by
    //    16 free cycles plus one cycle of pick latency.
    req = 2'b11;
    gt  = 0;
    for (int k = 0; k < 3; k++) begin
      tip = 1'b1;
      tick(10);
      tip = 1'b0;
      tick(40);
      req[gt] = 1'b0;
      d  = cyc;
      oh = (gt == 0) ? 2'b10 : 2'b01;
      exp_ev(d + 1, 2'b00, 1'b0);
      exp_ev(d + 18, oh, 1'b0);
      tick(4);
      req[gt] = 1'b1;
      tick(14);
      gt = 1 - gt;
    end

    // 3) Everyone releases; then in S_IDLE a foreign START coincides with a
    //    request. The foreign transfer wins; grant follows 17 cycles after STOP.
    req = 2'b00;
    d   = cyc;
    exp_ev(d + 1, 2'b00, 1'b0);
    tick(17);
    s   = cyc;
    tip = 1'b1;
    req = 2'b01;
    exp_pr(s, 2'b00, 1'b0, 1'b0);
    exp_pr(s + 1, 2'b00, 1'b0, 1'b1);
    tick(50);
    tip = 1'b0;
    t   = cyc;
    exp_ev(t + 17, 2'b01, 1'b0);
    tick(17);

    // 4) Requester 1 granted but never starts: revoked after 1024 cycles with
    //    a one-cycle timeout pulse, then regranted after the free period.
    req = 2'b10;
    d   = cyc;
    g   = d + 18;
    exp_ev(d + 1, 2'b00, 1'b0);
    exp_ev(g, 2'b10, 1'b0);
    exp_pr(g + 1023, 2'b10, 1'b0, 1'b1);
    exp_ev(g + 1024, 2'b00, 1'b1);
    exp_ev(g + 1025, 2'b00, 1'b0);
    exp_ev(g + 1041, 2'b10, 1'b0);
    tick(18 + 1041);

    // 5) Grantee releases mid-transfer; free count starts at STOP, not at
    //    the release.
    req = 2'b11;
    tip = 1'b1;
    tick(5);
    req = 2'b01;
    d   = cyc;
    exp_ev(d + 1, 2'b00, 1'b0);
    tick(30);
    tip = 1'b0;
    t   = cyc;
    exp_ev(t + 17, 2'b01, 1'b0);
    tick(17);

    // 6) Asynchronous reset mid-grant: grant drops before the next clock
    //    edge; afterwards requester 0 wins again despite having been last.
    req = 2'b11;
    tick(5);
    reset_n = 1'b0;
    r = cyc;
    exp_ev(r, 2'b00, 1'b0);
    exp_pr(r, 2'b00, 1'b0, 1'b1);
    tick(3);
    reset_n = 1'b1;
    e = cyc;
    exp_pr(e + 15, 2'b00, 1'b0, 1'b1);
    exp_ev(e + 17, 2'b01, 1'b0);
    tick(20);

    done = 1'b1;
  end

endmodule
